// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and the multi-cycle core's state and trap types.
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } op_code;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_TRAP
  } core_state_t;

  typedef enum logic [1:0] {
    TC_ILLEGAL        = 2'd0,
    TC_MISALIGN_LS    = 2'd1,
    TC_MISALIGN_FETCH = 2'd2
  } trap_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/rv_alu.sv
// Combinational RV32I ALU shared by register-register and register-immediate ops.
module rv_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] y
);

  logic signed [31:0] sa;
  logic signed [31:0] sb;

  assign sa = a;
  assign sb = b;

  always_comb begin
    y = '0;
    case (funct3)
      3'b000:  y = alt ? (a - b) : (a + b);
      3'b001:  y = a << b[4:0];
      3'b010:  y = {31'b0, sa < sb};
      3'b011:  y = {31'b0, a < b};
      3'b100:  y = a ^ b;
      3'b101:  y = alt ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  y = a | b;
      default: y = a & b;
    endcase
  end

endmodule

// File: rtl/rv_mc_core.sv
// Multi-cycle RV32I core: FSM-sequenced fetch/decode/execute/memory with
// handshaked instruction and data ports and precise traps.
module rv_mc_core
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] pc_o
);

  core_state_t state, state_nxt;
  trap_cause_t cause_q;
  logic [31:0] pc, ir, rs1_q, rs2_q, imm_q;
  logic [1:0]  ea_lo;
  logic [31:0] rf [32];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        legal, is_load, is_store, is_mem, writes_rd;
  logic [31:0] imm_dec, ea, alu_b, alu_y, target, next_pc, wb_val;
  logic        alu_alt, cond, take, mis_fetch, mis_ls;
  logic [3:0]  st_we;
  logic [31:0] st_data, lsh, load_val;
  logic signed [31:0] rs1_s, rs2_s;
  logic        rf_we;
  logic [31:0] rf_wd;

  assign opc       = ir[6:0];
  assign f3        = ir[14:12];
  assign rd        = ir[11:7];
  assign imem_addr = pc;
  assign pc_o      = pc;

  always_comb begin
    legal = 1'b0;
    case (opc)
      OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    case (opc)
      OP_STORE:        imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:       imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'b0};
      OP_JAL:          imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:         imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_mem    = is_load | is_store;
  assign writes_rd = (opc == OP_LUI) | (opc == OP_AUIPC) | (opc == OP_JAL) |
                     (opc == OP_JALR) | (opc == OP_IMM) | (opc == OP_REG);
  assign ea        = rs1_q + imm_q;
  assign mis_ls    = is_mem & (((f3[1:0] == 2'b01) & ea[0]) | (f3[1] & (ea[1:0] != 2'b00)));

  // Only SRAI among immediates uses funct7[5]; for ADDI that bit is part of imm.
  assign alu_alt = ((opc == OP_REG) | (f3 == 3'b101)) & ir[30];
  assign alu_b   = (opc == OP_REG) ? rs2_q : imm_q;

  rv_alu u_alu (
    .a      (rs1_q),
    .b      (alu_b),
    .funct3 (f3),
    .alt    (alu_alt),
    .y      (alu_y)
  );

  assign rs1_s = rs1_q;
  assign rs2_s = rs2_q;

  always_comb begin
    cond = 1'b0;
    case (f3)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b100:  cond = (rs1_s < rs2_s);
      3'b101:  cond = (rs1_s >= rs2_s);
      3'b110:  cond = (rs1_q < rs2_q);
      3'b111:  cond = (rs1_q >= rs2_q);
      default: cond = 1'b0;
    endcase
  end

  assign take      = (opc == OP_JAL) | (opc == OP_JALR) | ((opc == OP_BRANCH) & cond);
  assign target    = (opc == OP_JALR) ? (ea & ~32'd1) : (pc + imm_q);
  assign next_pc   = take ? target : (pc + 32'd4);
  assign mis_fetch = take & (target[1:0] != 2'b00);

  always_comb begin
    wb_val = alu_y;
    case (opc)
      OP_LUI:          wb_val = imm_q;
      OP_AUIPC:        wb_val = pc + imm_q;
      OP_JAL, OP_JALR: wb_val = pc + 32'd4;
      default:         wb_val = alu_y;
    endcase
  end

  always_comb begin
    st_we   = 4'b1111;
    st_data = rs2_q;
    case (f3)
      F3_B: begin
        st_we   = 4'b0001 << ea[1:0];
        st_data = {4{rs2_q[7:0]}};
      end
      F3_H: begin
        st_we   = 4'b0011 << ea[1:0];
        st_data = {2{rs2_q[15:0]}};
      end
      default: begin
        st_we   = 4'b1111;
        st_data = rs2_q;
      end
    endcase
  end

  assign lsh = dmem_rdata >> {ea_lo, 3'b000};

  always_comb begin
    load_val = dmem_rdata;
    case (f3)
      F3_B:    load_val = {{24{lsh[7]}}, lsh[7:0]};
      F3_H:    load_val = {{16{lsh[15]}}, lsh[15:0]};
      F3_BU:   load_val = {24'b0, lsh[7:0]};
      F3_HU:   load_val = {16'b0, lsh[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

  assign rf_we = (rd != 5'd0) &
                 (((state == S_EXEC) & writes_rd & ~mis_fetch) |
                  ((state == S_MEM) & dmem_ack & is_load));
  assign rf_wd = (state == S_MEM) ? load_val : wb_val;

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= rf_wd;
    if ((state == S_FETCH) && imem_ack) ir <= imem_rdata;
    if (state == S_DECODE) begin
      rs1_q   <= (ir[19:15] == 5'd0) ? 32'd0 : rf[ir[19:15]];
      rs2_q   <= (ir[24:20] == 5'd0) ? 32'd0 : rf[ir[24:20]];
      imm_q   <= imm_dec;
      cause_q <= TC_ILLEGAL;
    end
    if (state == S_EXEC) begin
      ea_lo   <= ea[1:0];
      cause_q <= mis_fetch ? TC_MISALIGN_FETCH : TC_MISALIGN_LS;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_BOOT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_mem) state_nxt = mis_ls ? S_TRAP : S_MEM;
        else        state_nxt = mis_fetch ? S_TRAP : S_FETCH;
      end
      S_MEM:    if (dmem_ack) state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_FETCH;
      default:  state_nxt = S_BOOT;
    endcase
  end

  // Requests derive from state so reset drops them asynchronously.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    retire   = 1'b0;
    trap     = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  retire   = ~is_mem & ~mis_fetch;
      S_MEM: begin
        dmem_req = 1'b1;
        retire   = dmem_ack;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      trap_cause <= 2'd0;
      trap_epc   <= 32'd0;
      dmem_addr  <= 32'd0;
      dmem_we    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      case (state)
        S_EXEC: begin
          if (is_mem && !mis_ls) begin
            dmem_addr <= {ea[31:2], 2'b00};
            dmem_we   <= is_store ? st_we : 4'd0;
            if (is_store) dmem_wdata <= st_data;
          end else if (!is_mem && !mis_fetch) begin
            pc <= next_pc;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            pc      <= pc + 32'd4;
            dmem_we <= 4'd0;
          end
        end
        S_TRAP: begin
          pc         <= TRAP_PC;
          trap_epc   <= pc;
          trap_cause <= cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv_mc_core.md
# rv_mc_core

Parametrised multi-cycle RV32I core that replaces the single-cycle CPU datapath/control with an explicit state machine and handshaked instruction and data memory ports, so instruction and data memories may insert any number of wait states. It also adds precise traps for illegal opcodes, misaligned loads and stores, and misaligned fetch targets, which the single-cycle core did not have. It sits between the memory subsystem and the testbench/top level and owns the PC, IR, register file and ALU.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- TRAP_PC, 32'h0000_0100: PC loaded on any trap.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until the ack cycle.
- imem_addr  out  32  fetch address (= PC); stable while imem_req is high.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  load/store request; held high until the ack cycle.
- dmem_we  out  4  byte write strobes; 0 for loads.
- dmem_addr  out  32  word-aligned address ({ea[31:2],2'b00}).
- dmem_wdata  out  32  store data, lane-replicated.
- dmem_ack  in  1  transfer complete; dmem_rdata is valid for loads.
- dmem_rdata  in  32  load data word.
- retire  out  1  one-cycle pulse per completed instruction.
- trap  out  1  one-cycle pulse on trap entry.
- trap_cause  out  2  0 = illegal instruction, 1 = misaligned load/store, 2 = misaligned fetch target; holds until the next trap.
- trap_epc  out  32  PC of the faulting instruction; holds until the next trap.
- pc_o  out  32  current architectural PC.

## Operation
- State machine states: BOOT, FETCH, DECODE, EXEC, MEM, TRAP. Reset state is BOOT.
- BOOT -> FETCH unconditionally on the first clock edge after reset release.
- FETCH: imem_req=1, imem_addr=PC. On imem_ack, IR <= imem_rdata, then go to DECODE.
- DECODE: read rs1/rs2, generate the immediate (I/S/B/U/J formats), classify the opcode.
  - Unknown opcode, or SYSTEM (1110011) -> TRAP with cause 0.
  - FENCE -> executes as a NOP.
  - Otherwise -> EXEC.
- EXEC: ALU for R/I types (funct3/funct7[5]); branch compare; next-PC; effective address ea = rs1 + imm.
  - Non-memory instructions: write rd, update PC, pulse retire, go to FETCH.
  - A jump or taken branch with target[1:0] != 0 -> TRAP with cause 2. rd is not written; PC is unchanged.
  - Load/store with ea misaligned for its size (H: ea[0] set; W: ea[1:0] != 0) -> TRAP with cause 1.
  - Otherwise load/store -> MEM.
- MEM: dmem_req=1, with dmem_we from funct3 and ea[1:0] (SB 0001<<ea[1:0]; SH 0011<<ea[1:0]; SW 1111).
  - Store data is replicated per lane: byte x4, half x2, word.
  - On dmem_ack:
    - Loads select the addressed lane and sign-extend (LB/LH) or zero-extend (LBU/LHU), then write rd.
    - PC += 4, pulse retire, go to FETCH.
- TRAP: trap=1, trap_epc <= PC, trap_cause set, PC <= TRAP_PC, go to FETCH. No register or memory side effects.
- Register file: x0 reads 0 and writes to it are discarded. Other registers are not reset.
- Arithmetic: all 32-bit, wrapping. Shifts use [4:0]. SLT is signed; SLTU is unsigned. JALR target = (rs1 + imm) & ~1.

## Timing
- Reset values: state=BOOT, PC=RESET_PC, imem_req=0, dmem_req=0, dmem_we=0, retire=0, trap=0, trap_cause=0, trap_epc=0, imem_addr=RESET_PC, dmem_addr=0, dmem_wdata=0.
- With zero wait states:
  - ALU/branch/jump instructions take 3 cycles (FETCH, DECODE, EXEC).
  - Loads and stores take 4 cycles (FETCH, DECODE, EXEC, MEM).
  - A trap takes 3 cycles (FETCH, DECODE, TRAP) or 4 cycles (FETCH, DECODE, EXEC, TRAP).
- Each wait cycle on imem_ack or dmem_ack adds one cycle. Ack may arrive in the same cycle that req rises.
- Ack sampled while the corresponding req is low is ignored.
- Exactly one outstanding transfer per port. The imem and dmem requests are never high together.
- Reset asserted mid-transfer aborts immediately: requests drop asynchronously and a late ack is ignored.
- retire and trap are mutually exclusive.

## Structure
- Add to riscv_pkg: `core_state_t` enum, `trap_cause_t` enum, and load/store funct3 constants. Reuse the existing `op_code` enum.
- Sub-module `rv_alu`: combinational, inputs a, b, funct3, alt; output y. Used for both R and I types.
- Register file array, immediate generation and the FSM stay inside rv_mc_core.

## Test plan
- Reset release with RESET_PC=0, imem returning ADDI x1,x0,5 with zero wait states -> imem_req first rises on cycle 2 after release; retire on cycle 4; x1=5; pc_o=4.
- SW x1,4(x0) with x1=32'hDEADBEEF, then LB x2,7(x0) with memory returning 32'hDEADBEEF -> dmem_we=1111, dmem_wdata=DEADBEEF; load reads dmem_addr=4, x2=32'hFFFFFFDE.
- imem_ack delayed 3 cycles on every fetch -> imem_addr stable and imem_req high throughout; ADDI latency is 6 cycles.
- LW at ea=0x2 -> trap pulse, trap_cause=1, trap_epc=faulting PC, pc_o=TRAP_PC; no dmem_req; rd unchanged.
- Opcode 7'b0000000 -> trap with cause 0 after DECODE. JALR to target 0x102 (bit 1 set) -> trap with cause 2; rd unchanged.
- reset_n asserted while dmem_req is high, with ack arriving after release -> ack ignored, FSM restarts from BOOT, PC=RESET_PC.
